// File: rtl/matrix_fetch_server.sv
// matrix_fetch_server: fetches row A[row] and column B[.][col]
// from two synchronous-read BRAMs and returns them with a val_rows strobe.
// Ports: clk_in/rst_in (sync, active high), mem_loaded/complete,
// new_request/row_req/col_req in, matA_row/matB_col/row_in/col_in/val_rows/
// busy out, a_en/a_addr/a_dout and b_en/b_addr/b_dout BRAM ports.
// Optional macro ROW_CACHE_EN: skip re-reading A when the row repeats.
module matrix_fetch_server #(
  parameter int DIM          = 32,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2,
  parameter int IDX_W        = $clog2(DIM),
  parameter int ADDR_W       = $clog2(DIM*DIM)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        mem_loaded,
  output logic                        complete,
  input  logic                        new_request,
  input  logic [IDX_W-1:0]            row_req,
  input  logic [IDX_W-1:0]            col_req,
  output logic [DIM-1:0][DATA_W-1:0]  matA_row,
  output logic [DIM-1:0][DATA_W-1:0]  matB_col,
  output logic [IDX_W-1:0]            row_in,
  output logic [IDX_W-1:0]            col_in,
  output logic                        val_rows,
  output logic                        busy,
  output logic                        a_en,
  output logic                        b_en,
  output logic [ADDR_W-1:0]           a_addr,
  output logic [ADDR_W-1:0]           b_addr,
  input  logic [DATA_W-1:0]           a_dout,
  input  logic [DATA_W-1:0]           b_dout
);

  localparam int RL = READ_LATENCY;
  localparam logic [IDX_W:0] DIM_L = (IDX_W+1)'(DIM);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM-1);
  localparam logic [ADDR_W-1:0] DIM_A = ADDR_W'(DIM);

  typedef enum logic [1:0] {IDLE, FETCH, RESPOND} state_t;

  state_t                    state;
  logic [IDX_W:0]            cnt;
  logic                      a_rd;
  logic                      b_rd;
  logic                      rd_v;
  logic [IDX_W-1:0]          rd_k;
  logic [RL-1:0]             pv;
  logic [RL-1:0][IDX_W-1:0]  pk;

  logic                      row_ok;
  logic                      col_ok;
  logic                      hit;
  logic                      cap;
  logic [IDX_W-1:0]          ck;

  assign row_ok = {1'b0, row_req} < DIM_L;
  assign col_ok = {1'b0, col_req} < DIM_L;
  assign cap    = pv[RL-1];
  assign ck     = pk[RL-1];

`ifdef ROW_CACHE_EN
  logic             c_v;
  logic [IDX_W-1:0] c_row;
  assign hit = c_v && (c_row == row_req);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      complete <= 1'b0;
      matA_row <= '0;
      matB_col <= '0;
      row_in   <= '0;
      col_in   <= '0;
      val_rows <= 1'b0;
      busy     <= 1'b0;
      a_en     <= 1'b0;
      b_en     <= 1'b0;
      a_addr   <= '0;
      b_addr   <= '0;
      cnt      <= '0;
      a_rd     <= 1'b0;
      b_rd     <= 1'b0;
      rd_v     <= 1'b0;
      rd_k     <= '0;
      pv       <= '0;
      pk       <= '0;
`ifdef ROW_CACHE_EN
      c_v      <= 1'b0;
      c_row    <= '0;
`endif
    end else begin
      complete <= mem_loaded;

      // Tag pipeline: stage RL-1 lines up with returning BRAM data.
      pv[0] <= rd_v;
      pk[0] <= rd_k;
      for (int i = 1; i < RL; i++) begin
        pv[i] <= pv[i-1];
        pk[i] <= pk[i-1];
      end

      if (cap) begin
        if (a_rd) matA_row[ck] <= a_dout;
        if (b_rd) matB_col[ck] <= b_dout;
      end

      unique case (state)
        IDLE: begin
          if (new_request && complete) begin
            row_in <= row_req;
            col_in <= col_req;
            cnt    <= '0;
            busy   <= 1'b1;
            a_rd   <= row_ok && !hit;
            b_rd   <= col_ok;
            // Out-of-range vectors return as zeros.
            if (!row_ok) matA_row <= '0;
            if (!col_ok) matB_col <= '0;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (cnt < DIM_L) begin
            a_en   <= a_rd;
            b_en   <= b_rd;
            a_addr <= ADDR_W'(row_in) * DIM_A
                      + ADDR_W'(cnt[IDX_W-1:0]);
            b_addr <= ADDR_W'(cnt[IDX_W-1:0]) * DIM_A
                      + ADDR_W'(col_in);
            rd_v   <= 1'b1;
            rd_k   <= cnt[IDX_W-1:0];
            cnt    <= cnt + 1'b1;
          end else begin
            a_en <= 1'b0;
            b_en <= 1'b0;
            rd_v <= 1'b0;
          end
          if (cap && ck == LAST) begin
            val_rows <= 1'b1;
            state    <= RESPOND;
`ifdef ROW_CACHE_EN
            c_row <= row_in;
            c_v   <= {1'b0, row_in} < DIM_L;
`endif
          end
        end
        RESPOND: begin
          val_rows <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

`ifdef ROW_CACHE_EN
      // Memory contents may change while not loaded.
      if (!complete) c_v <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_fetch_server.sv
// tb_matrix_fetch_server: random-data bench for matrix_fetch_server
// with a BRAM model and a high-level expected-vector model.
module tb_matrix_fetch_server;

  localparam int DIM = 32;
  localparam int LAT = 35;

  logic clk = 0;
  logic rst_in;
  logic mem_loaded;
  logic complete;
  logic new_request;
  logic [4:0] row_req, col_req;
  logic [DIM-1:0][7:0] matA_row, matB_col;
  logic [4:0] row_in, col_in;
  logic val_rows, busy, a_en, b_en;
  logic [9:0] a_addr, b_addr;
  logic [7:0] a_dout, b_dout;

  matrix_fetch_server dut (
    .clk_in(clk), .rst_in(rst_in),
    .mem_loaded(mem_loaded), .complete(complete),
    .new_request(new_request),
    .row_req(row_req), .col_req(col_req),
    .matA_row(matA_row), .matB_col(matB_col),
    .row_in(row_in), .col_in(col_in),
    .val_rows(val_rows), .busy(busy),
    .a_en(a_en), .b_en(b_en),
    .a_addr(a_addr), .b_addr(b_addr),
    .a_dout(a_dout), .b_dout(b_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_a [0:DIM*DIM-1];
  logic [7:0] mem_b [0:DIM*DIM-1];
  logic [7:0] a_s1, b_s1;

  // Two-cycle BRAM; garbage when not enabled.
  always @(posedge clk) begin
    a_s1   <= a_en ? mem_a[a_addr] : 8'($urandom);
    b_s1   <= b_en ? mem_b[b_addr] : 8'($urandom);
    a_dout <= a_s1;
    b_dout <= b_s1;
  end

  int cyc = 0;
  int a_cnt = 0;
  int b_cnt = 0;
  int v_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_en) a_cnt <= a_cnt + 1;
    if (b_en) b_cnt <= b_cnt + 1;
    if (val_rows) v_cnt <= v_cnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;
  bit cache_ok = 0;
  int cache_row = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DIM*DIM; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  task automatic do_req(input int r, input int c);
    int t0, a0, b0;
    bit got;
    logic [DIM-1:0][7:0] ea, eb;
    row_req = 5'(r);
    col_req = 5'(c);
    new_request = 1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (busy) got = 1;
    end
    chk("accept", 256'(got), 256'(1));
    if (!got) return;
    t0 = cyc; a0 = a_cnt; b0 = b_cnt;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (val_rows) got = 1;
    end
    chk("val_rows", 256'(got), 256'(1));
    chk("latency", 256'(cyc - t0), 256'(LAT));
    for (int k = 0; k < DIM; k++) begin
      ea[k] = mem_a[r*DIM + k];
      eb[k] = mem_b[k*DIM + c];
    end
    chk("row_in", 256'(row_in), 256'(r));
    chk("col_in", 256'(col_in), 256'(c));
    chk("matA_row", matA_row, ea);
    chk("matB_col", matB_col, eb);
`ifdef ROW_CACHE_EN
    chk("a_reads", 256'(a_cnt - a0),
        256'((cache_ok && cache_row == r) ? 0 : DIM));
`else
    chk("a_reads", 256'(a_cnt - a0), 256'(DIM));
`endif
    chk("b_reads", 256'(b_cnt - b0), 256'(DIM));
    cache_ok = 1;
    cache_row = r;
    @(posedge clk); #1;
    chk("strobe_1cyc", 256'(val_rows), 256'(0));
    new_request = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_val"}, 256'(val_rows), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_cmp"}, 256'(complete), 256'(0));
    chk({tag, "_en"}, 256'({a_en, b_en}), 256'(0));
    chk({tag, "_addr"}, 256'({a_addr, b_addr}), 256'(0));
    chk({tag, "_idx"}, 256'({row_in, col_in}), 256'(0));
    chk({tag, "_matA"}, matA_row, 256'(0));
    chk({tag, "_matB"}, matB_col, 256'(0));
  endtask

  initial begin
    int v0, bad, r, c;
    rst_in = 1;
    mem_loaded = 0;
    new_request = 0;
    row_req = 0;
    col_req = 0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        mem_a[i*DIM + j] = 8'(i + j);
        mem_b[i*DIM + j] = 8'(i ^ j);
      end
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_in = 0;

    // Known-pattern first request.
    mem_loaded = 1;
    do_req(0, 0);

    // Not loaded: no activity, then accept on 2nd edge.
    mem_loaded = 0;
    cache_ok = 0;
    @(posedge clk); #1;
    fill_random();
    r = int'($urandom_range(0, DIM-1));
    c = int'($urandom_range(0, DIM-1));
    row_req = 5'(r);
    col_req = 5'(c);
    new_request = 1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (a_en || b_en || busy) bad++;
    end
    chk("unloaded_idle", 256'(bad), 256'(0));
    mem_loaded = 1;
    @(posedge clk); #1;
    chk("early_accept", 256'(busy), 256'(0));
    do_req(r, c);

    // Full algorithm sweep.
    v0 = v_cnt;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        do_req(i, j);
    chk("strobe_count", 256'(v_cnt - v0), 256'(DIM*DIM));

    // Reset in the middle of a fetch.
    row_req = 5;
    col_req = 7;
    new_request = 1;
    bad = 1;
    for (int i = 0; i < 100 && bad != 0; i++) begin
      @(posedge clk); #1;
      if (busy) bad = 0;
    end
    chk("rst_accept", 256'(bad), 256'(0));
    repeat (11) @(posedge clk);
    #1;
    new_request = 0;
    rst_in = 1;
    @(posedge clk); #1;
    rst_in = 0;
    cache_ok = 0;
    chk_zero("midrst");
    v0 = v_cnt;
    repeat (45) @(posedge clk);
    #1;
    chk("no_strobe_after_rst", 256'(v_cnt - v0), 256'(0));
    do_req(9, 20);

    // Repeated row: A may come from the row cache.
    do_req(3, 0);
    do_req(3, 1);
    do_req(int'($urandom_range(0, DIM-1)), 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
